ssm2603_adc_capture: RTL and testbench

- I2S receiver for the SSM2603 ADC path; the capture-side counterpart of the DAC serializer that drives AUD_DACDAT/AUD_DACLRCK.
- Oversamples the codec's BCLK, ADCLRCK and ADCDAT in the 18.432 MHz system clock domain and deserializes 32-bit left/right slots.
- Presents signed stereo sample pairs to the DSP or UART side with a valid/ack handshake, plus overrun and framing-error flags.

---
 rtl/ssm2603_adc_capture.sv | 209 ++++++++++++++++++++
 tb/tb_ssm2603_adc_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ssm2603_adc_capture.sv
// ssm2603_adc_capture
//
// I2S receiver for the SSM2603 ADC path. BCLK, ADCLRCK and ADCDAT are
// oversampled in the system clock domain. Each BCLK rising edge becomes a
// one-cycle "tick". The top SAMPLE_BITS of every SLOT_BITS-wide slot are
// deserialized MSB first. Complete left/right pairs are published to the
// consumer through a valid/ack handshake.
//
// Ports:
//   clock           system clock (18.432 MHz)
//   reset           asynchronous active-low reset
//   in_bclk         codec bit clock
//   in_lrck         ADCLRCK, 0 = left slot, 1 = right slot
//   in_adcdat       serial ADC data, changes on BCLK falling edges
//   in_ack          consumer has taken the current pair
//   out_sample_l    left sample, two's complement
//   out_sample_r    right sample, two's complement
//   out_valid       sample pair available
//   out_overrun     one-cycle pulse, an unacknowledged pair was overwritten
//   out_frame_error one-cycle pulse, slot length was not SLOT_BITS
//   out_locked      frame alignment established
module ssm2603_adc_capture #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_bclk,
    input  logic                   in_lrck,
    input  logic                   in_adcdat,
    input  logic                   in_ack,
    output logic [SAMPLE_BITS-1:0] out_sample_l,
    output logic [SAMPLE_BITS-1:0] out_sample_r,
    output logic                   out_valid,
    output logic                   out_overrun,
    output logic                   out_frame_error,
    output logic                   out_locked
);

    localparam int CNT_W = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {ST_UNLOCKED, ST_LOCKED} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   bclk_prev_q, bclk_prev_d;
    logic                   lrck_prev_q, lrck_prev_d;
    logic                   channel_q, channel_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_l_q, shift_l_d;
    logic [SAMPLE_BITS-1:0] shift_r_q, shift_r_d;
    state_t                 state_q, state_d;
    logic                   left_ok_q, left_ok_d;
    logic [SAMPLE_BITS-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_BITS-1:0] sample_r_q, sample_r_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_error_q, frame_error_d;

    logic bclk_s, lrck_s, dat_s;
    logic tick, boundary, len_ok, publish;

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        bclk_sync_d    = bclk_sync_q;
        lrck_sync_d    = lrck_sync_q;
        dat_sync_d     = dat_sync_q;
        bclk_sync_d[0] = in_bclk;
        lrck_sync_d[0] = in_lrck;
        dat_sync_d[0]  = in_adcdat;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            bclk_sync_d[i] = bclk_sync_q[i-1];
            lrck_sync_d[i] = lrck_sync_q[i-1];
            dat_sync_d[i]  = dat_sync_q[i-1];
        end
    end

    always_comb begin
        bclk_prev_d   = bclk_s;
        lrck_prev_d   = lrck_prev_q;
        channel_d     = channel_q;
        bit_cnt_d     = bit_cnt_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        state_d       = state_q;
        left_ok_d     = left_ok_q;
        sample_l_d    = sample_l_q;
        sample_r_d    = sample_r_q;
        valid_d       = valid_q;
        overrun_d     = 1'b0;
        frame_error_d = 1'b0;
        publish       = 1'b0;

        tick     = bclk_s & ~bclk_prev_q;
        boundary = tick & (lrck_s != lrck_prev_q);
        // The boundary tick arrives SLOT_BITS ticks after the previous one,
        // so the counter has reached SLOT_BITS-1 by then.
        len_ok   = (bit_cnt_q == CNT_LAST);

        if (tick) begin
            lrck_prev_d = lrck_s;
            if (boundary) begin
                // The data bit on this tick is the trailing bit of the
                // previous word (I2S one-bit delay) and is dropped.
                bit_cnt_d = '0;
                channel_d = lrck_s;
                case (state_q)
                    ST_UNLOCKED: begin
                        if (!lrck_s) begin
                            state_d   = ST_LOCKED;
                            left_ok_d = 1'b0;
                        end
                    end
                    default: begin
                        if (!len_ok) begin
                            frame_error_d = 1'b1;
                            state_d       = ST_UNLOCKED;
                            left_ok_d     = 1'b0;
                        end else if (lrck_s) begin
                            // The left slot ended with the correct length.
                            left_ok_d = 1'b1;
                        end else begin
                            // The right slot ended correctly. Publish only
                            // when the left slot of this frame also did.
                            left_ok_d = 1'b0;
                            publish   = left_ok_q;
                        end
                    end
                endcase
            end else begin
                if (bit_cnt_q < CNT_SLOT) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
                if (bit_cnt_q < CNT_SAMP) begin
                    if (channel_q) begin
                        shift_r_d = {shift_r_q[SAMPLE_BITS-2:0], dat_s};
                    end else begin
                        shift_l_d = {shift_l_q[SAMPLE_BITS-2:0], dat_s};
                    end
                end
            end
        end

        // A publish takes priority over an ack arriving in the same cycle.
        if (publish) begin
            sample_l_d = shift_l_q;
            sample_r_d = shift_r_q;
            valid_d    = 1'b1;
            overrun_d  = valid_q & ~in_ack;
        end else if (valid_q && in_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bclk_sync_q   <= '0;
            lrck_sync_q   <= '0;
            dat_sync_q    <= '0;
            bclk_prev_q   <= 1'b0;
            lrck_prev_q   <= 1'b0;
            channel_q     <= 1'b0;
            bit_cnt_q     <= '0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            state_q       <= ST_UNLOCKED;
            left_ok_q     <= 1'b0;
            sample_l_q    <= '0;
            sample_r_q    <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            bclk_sync_q   <= bclk_sync_d;
            lrck_sync_q   <= lrck_sync_d;
            dat_sync_q    <= dat_sync_d;
            bclk_prev_q   <= bclk_prev_d;
            lrck_prev_q   <= lrck_prev_d;
            channel_q     <= channel_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            state_q       <= state_d;
            left_ok_q     <= left_ok_d;
            sample_l_q    <= sample_l_d;
            sample_r_q    <= sample_r_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign out_sample_l    = sample_l_q;
    assign out_sample_r    = sample_r_q;
    assign out_valid       = valid_q;
    assign out_overrun     = overrun_q;
    assign out_frame_error = frame_error_q;
    assign out_locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ssm2603_adc_capture.sv
// Directed bench for ssm2603_adc_capture. It drives BCLK at clock/9
// (4 low / 5 high) with LRCK and data changing on the BCLK fall. Outputs
// are sampled on the falling system-clock edge.
module tb_ssm2603_adc_capture;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_bclk = 1'b0;
    logic        in_lrck = 1'b0;
    logic        in_adcdat = 1'b0;
    logic        in_ack = 1'b0;
    logic [15:0] out_sample_l, out_sample_r;
    logic        out_valid, out_overrun, out_frame_error, out_locked;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0, fe_cnt = 0, pub_cnt = 0;
    int ov0, fe0, pub0;
    logic valid_seen = 1'b0;

    ssm2603_adc_capture #(.SAMPLE_BITS(16), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_bclk        (in_bclk),
        .in_lrck        (in_lrck),
        .in_adcdat      (in_adcdat),
        .in_ack         (in_ack),
        .out_sample_l   (out_sample_l),
        .out_sample_r   (out_sample_r),
        .out_valid      (out_valid),
        .out_overrun    (out_overrun),
        .out_frame_error(out_frame_error),
        .out_locked     (out_locked)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One system clock; outputs are sampled on the falling edge and the
    // pulse/publish events are counted.
    task automatic step();
        @(negedge clock);
        if (out_overrun) ov_cnt++;
        if (out_frame_error) fe_cnt++;
        if (out_valid && !valid_seen) pub_cnt++;
        valid_seen = out_valid;
    endtask

    // Sends BCLK periods [first,last) of one slot. Period 0 carries the
    // previous word's trailing bit. Periods 1..16 carry w MSB first, and
    // the remaining periods carry random filler. With ack_pub set, in_ack is
    // high in exactly the cycle whose closing edge registers a publish
    // caused by the first period's rising edge.
    task automatic send_bits(input logic lr, input logic [15:0] w,
                             input int first, input int last, input bit ack_pub);
        for (int p = first; p < last; p++) begin
            in_bclk   = 1'b0;
            in_lrck   = lr;
            in_adcdat = (p >= 1 && p <= 16) ? w[16-p] : 1'($urandom_range(1, 0));
            repeat (4) step();
            in_bclk = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step();
                if (ack_pub && p == first && i == 1) in_ack = 1'b1;
                if (i == 2) in_ack = 1'b0;
            end
        end
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] w);
        send_bits(lr, w, 0, 32, 1'b0);
    endtask

    task automatic ack_pulse();
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_l", 32'(out_sample_l), 32'h0);
        check("rst_r", 32'(out_sample_r), 32'h0);
        check("rst_locked", 32'(out_locked), 32'd0);
        check("rst_overrun", 32'(out_overrun), 32'd0);
        check("rst_ferr", 32'(out_frame_error), 32'd0);
        reset = 1'b1;

        // First frame begins on LRCK=0, so there is no 1->0 boundary yet.
        send_slot(1'b0, 16'h0F0F);
        send_slot(1'b1, 16'hF0F0);
        check("unlocked_first_frame", 32'(out_locked), 32'd0);
        send_slot(1'b0, 16'h8001);
        check("locked_after_left", 32'(out_locked), 32'd1);
        check("no_valid_first_left", 32'(out_valid), 32'd0);
        send_slot(1'b1, 16'h7FFE);
        check("no_valid_before_pub", 32'(out_valid), 32'd0);
        send_slot(1'b0, 16'h1234);
        check("pub1_valid", 32'(out_valid), 32'd1);
        check("pub1_l", 32'(out_sample_l), 32'h8001);
        check("pub1_r", 32'(out_sample_r), 32'h7FFE);
        ack_pulse();
        check("ack_clears", 32'(out_valid), 32'd0);

        // Two frames without ack: the second publish overruns.
        send_slot(1'b1, 16'h5678);
        ov0 = ov_cnt;
        send_slot(1'b0, 16'h9ABC);
        check("pub2_valid", 32'(out_valid), 32'd1);
        check("pub2_l", 32'(out_sample_l), 32'h1234);
        check("pub2_r", 32'(out_sample_r), 32'h5678);
        check("pub2_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        send_slot(1'b1, 16'hDEF0);
        send_slot(1'b0, 16'h1111);
        check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("overrun_valid", 32'(out_valid), 32'd1);
        check("overrun_l", 32'(out_sample_l), 32'h9ABC);
        check("overrun_r", 32'(out_sample_r), 32'hDEF0);

        // Ack in the same cycle as a publish while valid is already high.
        send_slot(1'b1, 16'h2222);
        ov0 = ov_cnt;
        send_bits(1'b0, 16'h3333, 0, 32, 1'b1);
        check("simul_valid", 32'(out_valid), 32'd1);
        check("simul_l", 32'(out_sample_l), 32'h1111);
        check("simul_r", 32'(out_sample_r), 32'h2222);
        check("simul_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        ack_pulse();
        check("simul_ack_clears", 32'(out_valid), 32'd0);

        // Right slot shortened to 30 BCLKs.
        fe0  = fe_cnt;
        pub0 = pub_cnt;
        send_bits(1'b1, 16'h4444, 0, 30, 1'b0);
        send_slot(1'b0, 16'h0000);
        check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_unlocked", 32'(out_locked), 32'd0);
        check("ferr_no_valid", 32'(out_valid), 32'd0);
        send_slot(1'b1, 16'h0000);
        check("ferr_still_unlocked", 32'(out_locked), 32'd0);
        send_slot(1'b0, 16'h5555);
        check("relock", 32'(out_locked), 32'd1);
        send_slot(1'b1, 16'h6666);
        send_slot(1'b0, 16'h7777);
        check("relock_pub_count", 32'(pub_cnt - pub0), 32'd1);
        check("relock_l", 32'(out_sample_l), 32'h5555);
        check("relock_r", 32'(out_sample_r), 32'h6666);
        check("relock_fe_once", 32'(fe_cnt - fe0), 32'd1);

        // One-cycle reset mid right slot while out_valid=1.
        send_bits(1'b1, 16'h8888, 0, 10, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_l", 32'(out_sample_l), 32'h0);
        check("async_rst_r", 32'(out_sample_r), 32'h0);
        check("async_rst_locked", 32'(out_locked), 32'd0);
        step();
        reset = 1'b1;
        pub0 = pub_cnt;
        send_bits(1'b1, 16'h8888, 10, 32, 1'b0);
        check("partial_unlocked", 32'(out_locked), 32'd0);
        send_slot(1'b0, 16'hAAAA);
        check("rst_relock", 32'(out_locked), 32'd1);
        check("rst_no_partial_pub", 32'(out_valid), 32'd0);
        send_slot(1'b1, 16'hBBBB);
        send_slot(1'b0, 16'hCCCC);
        check("rst_pub_count", 32'(pub_cnt - pub0), 32'd1);
        check("rst_pub_l", 32'(out_sample_l), 32'hAAAA);
        check("rst_pub_r", 32'(out_sample_r), 32'hBBBB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
